// File: rtl/sequence_detector_pkg.sv
// sequence_detector_pkg: shared symbol width, target sequence, state type and mismatch fallback
package sequence_detector_pkg;
  localparam int DATA_W = 3;
  localparam int SEQ_LEN = 8;
  typedef logic [DATA_W-1:0] sym_t;
  localparam sym_t SEQ [0:SEQ_LEN-1] = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;
  // 001 is the only proper prefix that can also end a broken run
  function automatic state_t next_on_mismatch(input sym_t d);
    return d == SEQ[0] ? S1 : S0;
  endfunction
endpackage

// File: rtl/sequence_detector_if.sv
// sequence_detector_if: symbol stream and detection outputs; match_count exists only with SEQDET_MATCH_COUNT_EN
interface sequence_detector_if;
  import sequence_detector_pkg::*;
  sym_t data;
  logic sequence_found;
`ifdef SEQDET_MATCH_COUNT_EN
  logic [7:0] match_count;
  modport master (output data, input sequence_found, input match_count);
  modport slave (input data, output sequence_found, output match_count);
`else
  modport master (output data, input sequence_found);
  modport slave (input data, output sequence_found);
`endif
endinterface

// File: rtl/sequence_detector_sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-high reset
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/sequence_detector.sv
// sequence_detector: 8-symbol serial pattern detector with registered pulse; SEQDET_MATCH_COUNT_EN adds a saturating match counter
module sequence_detector
  import sequence_detector_pkg::*;
(
  input logic clk,
  input logic reset,
  sequence_detector_if.slave sif
);
  state_t state, state_nx;
  logic hit, done;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S0;
      sif.sequence_found <= 1'b0;
    end else begin
      state <= state_nx;
      sif.sequence_found <= done;
    end
  always_comb begin
    hit = sif.data == SEQ[state];
    done = hit && state == S7;
    state_nx = !hit ? next_on_mismatch(sif.data) : done ? S0 : state_t'(state + 3'd1);
  end
`ifdef SEQDET_MATCH_COUNT_EN
  sat_counter #(.W(8)) u_cnt (.clk(clk), .reset(reset), .inc(done), .count(sif.match_count));
`endif
endmodule

// File: tb/tb_sequence_detector.sv
// tb_sequence_detector: directed table, async-reset corners and random stream against a sliding-window model
module tb_sequence_detector;
  import sequence_detector_pkg::*;
  logic clk = 0, reset = 1;
  int checks = 0, errors = 0;
  sym_t hist[$];
  int cnt = 0;
  typedef struct { logic rst; sym_t d; logic e; } vec_t;
  vec_t vecs[$];
  sequence_detector_if sif();
  sequence_detector dut (.clk(clk), .reset(reset), .sif(sif));
  always #5 clk = ~clk;
  task automatic check(input logic [31:0] got, input logic [31:0] exp, input string nm);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic predict(input sym_t d);
    sym_t w[$];
    w = hist;
    w.push_back(d);
    if (w.size() > SEQ_LEN) void'(w.pop_front());
    if (w.size() != SEQ_LEN) return 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) if (w[i] != SEQ[i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic drive(input sym_t d, input logic e, input string nm);
    logic h;
    h = predict(d);
    sif.data = d;
    @(posedge clk);
    #1;
    hist.push_back(d);
    if (hist.size() > SEQ_LEN) void'(hist.pop_front());
    if (h && cnt < 255) cnt++;
    check(sif.sequence_found, e, nm);
`ifdef SEQDET_MATCH_COUNT_EN
    check(sif.match_count, cnt, {nm, "_count"});
`endif
  endtask
  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1;
    #1;
    hist.delete();
    cnt = 0;
    check(sif.sequence_found, 0, nm);
    check(dut.state, S0, {nm, "_state"});
`ifdef SEQDET_MATCH_COUNT_EN
    check(sif.match_count, 0, {nm, "_count"});
`endif
    @(negedge clk);
    reset = 0;
  endtask
  task automatic add(input logic r, input sym_t d, input logic e);
    vecs.push_back('{rst: r, d: d, e: e});
  endtask
  task automatic add_seq(input sym_t last, input logic e);
    for (int i = 0; i < SEQ_LEN - 1; i++) add(0, SEQ[i], 0);
    add(0, last, e);
  endtask
  initial begin
    sif.data = '0;
    repeat (2) @(posedge clk);
    #1;
    check(sif.sequence_found, 0, "reset_found");
    check(dut.state, S0, "reset_state");
    @(negedge clk);
    reset = 0;
    add(1, 0, 0);
    add_seq(3'b101, 1);
    add(0, 3'b000, 0);
    add_seq(3'b111, 0);
    add(0, 3'b000, 0);
    add(0, 3'b001, 0); add(0, 3'b101, 0); add(0, 3'b110, 0);
    add(1, 0, 0);
    add(0, 3'b110, 0); add(0, 3'b110, 0); add(0, 3'b011, 0); add(0, 3'b101, 0);
    add(0, 3'b001, 0);
    add_seq(3'b101, 1);
    add(1, 0, 0);
    add(0, 3'b101, 0); add(0, 3'b101, 0);
    add_seq(3'b101, 1);
    add_seq(3'b101, 1);
    add(0, 3'b001, 0);
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].rst) do_reset($sformatf("vec%0d_rst", i));
      else drive(vecs[i].d, vecs[i].e, $sformatf("vec%0d", i));
`ifdef SEQDET_MATCH_COUNT_EN
    check(sif.match_count, 2, "back_to_back_count");
`endif
    do_reset("pre_async");
    for (int i = 0; i < 6; i++) drive(SEQ[i], 0, "to_s6");
    check(dut.state, S6, "in_s6");
    #2 reset = 1;
    #1;
    check(dut.state, S0, "async_s6_state");
    check(sif.sequence_found, 0, "async_s6_found");
    @(negedge clk);
    reset = 0;
    hist.delete();
    cnt = 0;
    drive(SEQ[6], 0, "after_async_6");
    drive(SEQ[7], 0, "after_async_7");
    for (int i = 0; i < SEQ_LEN - 1; i++) drive(SEQ[i], 0, "pulse_pre");
    drive(SEQ[7], 1, "pulse_hit");
    #2 reset = 1;
    #1;
    check(sif.sequence_found, 0, "async_pulse_drop");
    @(negedge clk);
    reset = 0;
    hist.delete();
    cnt = 0;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) do_reset("rnd_rst");
      else if (r < 50) begin
        int bad;
        sym_t s;
        bad = $urandom_range(0, 3) == 0 ? $urandom_range(0, SEQ_LEN - 1) : -1;
        for (int i = 0; i < SEQ_LEN; i++) begin
          s = i == bad ? sym_t'($urandom) : SEQ[i];
          drive(s, predict(s), "rnd_seq");
        end
      end else begin
        sym_t s;
        s = sym_t'($urandom);
        drive(s, predict(s), "rnd_sym");
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
